seven_seg_scanner: RTL

- Time-multiplexed scan controller directly upstream of the 7-segment decoder: holds NUM_DIGITS packed BCD digits and presents one digit at a time on bcd_out.
- Drives active-low common-digit enables and inserts a blanking dead-time between digits to prevent ghosting.
- New display values go in through a valid/ready write port and are applied only at frame boundaries, so a frame is never torn.
- Optional leading-zero blanking.

---
 rtl/seg7_pkg.sv | 12 +
 rtl/seven_seg_scanner_scan_prescaler.sv | 49 ++++
 rtl/seven_seg_scanner.sv | 108 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan path: digit width, blank code and scan phase.
package seg7_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

    typedef enum logic {
        BLANK,
        SHOW
    } scan_phase_e;

endpackage

// File: rtl/seven_seg_scanner_scan_prescaler.sv
// Digit-slot timebase: per-slot clock counter, slot index, dead-time phase and frame-end strobe.
module scan_prescaler
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned PRESCALE     = 1000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned SLOT_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [SLOT_W-1:0] slot_d,
    output scan_phase_e       phase_d,
    output logic              frame_end
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(PRESCALE - 1);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]  BLANK_LIM = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SLOT_W-1:0] slot_q;

    // Next-state values are exported so the top can register outputs that
    // match the counter value of the same cycle.
    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        slot_d    = slot_q;
        frame_end = 1'b0;
        if (cnt_q == CNT_MAX) begin
            cnt_d     = '0;
            frame_end = (slot_q == SLOT_MAX);
            slot_d    = (slot_q == SLOT_MAX) ? '0 : slot_q + 1'b1;
        end
        phase_d = (cnt_d < BLANK_LIM) ? BLANK : SHOW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            slot_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed BCD display scanner with frame-synchronous write buffer and leading-zero blanking.
module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned PRESCALE     = 1000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic                          lzb_en,
    output logic [DIGIT_W-1:0]            bcd_out,
    output logic [NUM_DIGITS-1:0]         digit_en_n,
    output logic                          frame_done
);

    localparam int unsigned SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [SLOT_W-1:0]             slot_d;
    scan_phase_e                   phase_d;
    logic                          frame_end;

    logic [DIGIT_W*NUM_DIGITS-1:0] disp_q, disp_d, buf_q, buf_d;
    logic                          pend_q, pend_d;
    logic [DIGIT_W-1:0]            bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]         en_n_q, en_n_d;
    logic                          frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0]         lz_blank;

    scan_prescaler #(
        .NUM_DIGITS   (NUM_DIGITS),
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES),
        .SLOT_W       (SLOT_W)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .slot_d    (slot_d),
        .phase_d   (phase_d),
        .frame_end (frame_end)
    );

    always_comb begin
        disp_d       = disp_q;
        buf_d        = buf_q;
        pend_d       = pend_q;
        frame_done_d = frame_end;
        if (frame_end && pend_q) begin
            disp_d = buf_q;
            pend_d = 1'b0;
        end
        if (wr_valid && !pend_q) begin
            buf_d  = digits_in;
            pend_d = 1'b1;
        end
    end

    // Scan from the top digit down; a digit is blanked while all digits at or above it are zero.
    always_comb begin
        logic all_zero;
        int unsigned idx;
        all_zero = 1'b1;
        lz_blank = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            idx      = NUM_DIGITS - 1 - k;
            all_zero = all_zero && (disp_d[idx*DIGIT_W +: DIGIT_W] == '0);
            lz_blank[idx] = lzb_en && (idx != 0) && all_zero;
        end
    end

    always_comb begin
        bcd_d  = BLANK_CODE;
        en_n_d = '1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if ((SLOT_W'(k) == slot_d) && (phase_d == SHOW) && !lz_blank[k]) begin
                bcd_d     = disp_d[k*DIGIT_W +: DIGIT_W];
                en_n_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q       <= '1;
            buf_q        <= '0;
            pend_q       <= 1'b0;
            bcd_q        <= BLANK_CODE;
            en_n_q       <= '1;
            frame_done_q <= 1'b0;
        end else begin
            disp_q       <= disp_d;
            buf_q        <= buf_d;
            pend_q       <= pend_d;
            bcd_q        <= bcd_d;
            en_n_q       <= en_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wr_ready   = !pend_q;
    assign bcd_out    = bcd_q;
    assign digit_en_n = en_n_q;
    assign frame_done = frame_done_q;

endmodule
